batchnorm_stream: RTL
=====================

Name: batchnorm_stream

Overview:
- Streaming, parametrised per-channel batch-normalisation (inference form) for the CNN datapath. Sits between a conv/accumulate stage and the activation/pool stage.
- Consumes one channel-interleaved sample per accepted beat and computes y = sat(round(x*scale[c] + bias[c])), with optional fused ReLU.
- scale = gamma/sqrt(var+eps) and bias = beta - mean*scale are precomputed offline and loaded through a coefficient write port.
- Replaces a fixed-size, non-synthesisable array-based normaliser with a valid/ready pipeline of any channel count.

Parameters:
- DATA_W, 8: signed width of input/output samples.
- COEF_W, 16: signed width of scale and bias coefficients.
- FRAC_W, 8: fractional bits of scale and bias (Q format); must be >= 1 and < COEF_W.
- NUM_CH, 64: channel count; channel counter range 0..NUM_CH-1; must be >= 1.
- CH_W, $clog2(NUM_CH) (min 1): width of channel index signals.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- relu_en  in  1  fused ReLU enable, sampled per sample on accept.
- ch_clear  in  1  forces channel counter to 0 on the next edge.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  CH_W  channel to write.
- coef_scale  in  COEF_W  signed scale, Q(COEF_W-FRAC_W).FRAC_W.
- coef_bias  in  COEF_W  signed bias, same Q format.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  signed normalised sample.
- out_ch  out  CH_W  channel index of out_data.

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Channel counter = 0; all internal stage-valid bits = 0.
  - Every coefficient entry: scale = 1<<FRAC_W (1.0), bias = 0. This gives identity by default.
- Reset mid-stream discards all in-flight samples. No output beat appears for them.
- Handshake:
  - A sample is accepted when in_valid && in_ready.
  - A beat is delivered when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready); the whole pipeline stalls together.
  - While stalled, out_data, out_ch and out_valid hold stable.
  - in_ready has no combinational dependency on in_valid.
- Pipeline, 3 stages. Latency is exactly 3 cycles from accept edge to out_valid with no stall. Full throughput is 1 sample/cycle.
  - S1 registers x, scale[ch], bias[ch], ch, relu_en.
  - S2 computes p = x*scale (DATA_W+COEF_W signed, full precision), then s = p + sign-extended bias. It uses one guard bit (width DATA_W+COEF_W+1).
  - S3:
    - r = (s + (1<<(FRAC_W-1))) >>> FRAC_W, i.e. round half toward +inf with arithmetic shift.
    - Saturate r to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
    - If relu_en (as captured) and the result is < 0, output 0.
- Channel counter:
  - Increments on each accepted sample. Wraps NUM_CH-1 -> 0.
  - ch_clear sets it to 0 and takes priority over the increment. A sample accepted in the same cycle as ch_clear uses the pre-clear channel; the next sample uses channel 0.
  - If NUM_CH = 1, the counter stays 0.
- Coefficient memory:
  - Register array NUM_CH x 2 x COEF_W. Written on coef_we at the clock edge, independent of stall.
  - coef_addr >= NUM_CH: write is ignored.
  - Write and accept to the same channel in the same cycle: the accepted sample uses the OLD coefficients. The new values apply from the next accepted sample.
- relu_en may change at any cycle. It affects only samples accepted while it is asserted.

Test Plan:
- Identity after reset: NUM_CH=4, rst 2 cycles, stream x = 5, -7, 127, -128 -> out_data 5, -7, 127, -128; out_ch 0,1,2,3; first out_valid exactly 3 cycles after first accept.
- Scale/bias/rounding: ch0 scale=0x0180 (1.5), bias=0x0080 (0.5); x=10 -> 16 (15.5 rounds up); x=-3 -> -4 (-4.0); x=-1 -> -1 (-1.0). With bias=0: x=-3 -> -4 (-4.5 rounds to -4).
- Saturation and ReLU: scale=0x0200 (2.0), bias=0. x=127 -> 127; x=-128 -> -128. Same with relu_en=1: x=-128 -> 0, x=3 -> 6.
- Channel wrap and clear: NUM_CH=4, 6 accepts -> out_ch 0,1,2,3,0,1. Assert ch_clear with the 3rd accept -> out_ch 0,1,2,0,1,2.
- Backpressure: continuous in_valid, out_ready low for 5 cycles mid-stream -> in_ready low while out_valid && !out_ready, output held stable, no sample lost or duplicated (compare against a reference model over 200 random samples and random out_ready).
- Coefficient write collision and reset: write ch1 scale=0x0300 in the same cycle as accepting a ch1 sample x=4 -> output 4 (old 1.0); the next ch1 sample x=4 -> 12. Assert rst with 2 samples in flight -> no out_valid afterwards, coefficients back to identity.

Source files
------------

// File: rtl/batchnorm_stream.sv
// Streaming per-channel batch-normalisation (inference form): y = sat(round(x*scale[c] + bias[c])),
// with optional fused ReLU. This is a three-stage valid/ready pipeline that stalls as a whole.
module batchnorm_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned NUM_CH = 64,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              relu_en,
    input  logic              ch_clear,
    input  logic              coef_we,
    input  logic [CH_W-1:0]   coef_addr,
    input  logic [COEF_W-1:0] coef_scale,
    input  logic [COEF_W-1:0] coef_bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam logic signed [COEF_W-1:0] ONE_Q   = COEF_W'(1 << FRAC_W);
    localparam logic signed [SUM_W-1:0]  HALF_Q  = SUM_W'(1 << (FRAC_W - 1));
    localparam logic signed [SUM_W-1:0]  OUT_MAX = SUM_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0]  OUT_MIN = ~OUT_MAX;
    localparam logic [CH_W-1:0]          CH_LAST = CH_W'(NUM_CH - 1);

    logic adv_c;
    logic accept_c;

    logic [CH_W-1:0] ch_q, ch_d;
    logic signed [COEF_W-1:0] scale_q [NUM_CH];
    logic signed [COEF_W-1:0] scale_d [NUM_CH];
    logic signed [COEF_W-1:0] bias_q  [NUM_CH];
    logic signed [COEF_W-1:0] bias_d  [NUM_CH];

    logic                     s1_v_q, s1_v_d;
    logic signed [DATA_W-1:0] s1_x_q, s1_x_d;
    logic signed [COEF_W-1:0] s1_scale_q, s1_scale_d;
    logic signed [COEF_W-1:0] s1_bias_q, s1_bias_d;
    logic [CH_W-1:0]          s1_ch_q, s1_ch_d;
    logic                     s1_relu_q, s1_relu_d;

    logic                     s2_v_q, s2_v_d;
    logic signed [SUM_W-1:0]  s2_sum_q, s2_sum_d;
    logic [CH_W-1:0]          s2_ch_q, s2_ch_d;
    logic                     s2_relu_q, s2_relu_d;

    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;

    logic signed [PROD_W-1:0] x_ext_c, scale_ext_c, prod_c;
    logic signed [SUM_W-1:0]  sum_c, rnd_c, shr_c;
    logic signed [DATA_W-1:0] sat_c, res_c;

    // Whole pipeline advances unless a valid output is being held back.
    assign adv_c    = !(out_valid_q && !out_ready);
    assign accept_c = in_valid && adv_c;

    assign in_ready  = adv_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    // Datapath arithmetic: multiply-accumulate in S2, round/saturate/ReLU in S3.
    always_comb begin
        x_ext_c     = PROD_W'(s1_x_q);
        scale_ext_c = PROD_W'(s1_scale_q);
        prod_c      = x_ext_c * scale_ext_c;
        sum_c       = SUM_W'(prod_c) + SUM_W'(s1_bias_q);

        rnd_c = s2_sum_q + HALF_Q;
        shr_c = rnd_c >>> FRAC_W;
        if (shr_c > OUT_MAX) begin
            sat_c = DATA_W'(OUT_MAX);
        end else if (shr_c < OUT_MIN) begin
            sat_c = DATA_W'(OUT_MIN);
        end else begin
            sat_c = DATA_W'(shr_c);
        end
        res_c = (s2_relu_q && sat_c[DATA_W-1]) ? '0 : sat_c;
    end

    always_comb begin
        scale_d = scale_q;
        bias_d  = bias_q;
        ch_d    = ch_q;

        s1_v_d     = s1_v_q;
        s1_x_d     = s1_x_q;
        s1_scale_d = s1_scale_q;
        s1_bias_d  = s1_bias_q;
        s1_ch_d    = s1_ch_q;
        s1_relu_d  = s1_relu_q;

        s2_v_d    = s2_v_q;
        s2_sum_d  = s2_sum_q;
        s2_ch_d   = s2_ch_q;
        s2_relu_d = s2_relu_q;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;

        // Coefficient writes land regardless of stall; S1 below reads the pre-write value.
        if (coef_we && (32'(coef_addr) < NUM_CH)) begin
            scale_d[coef_addr] = coef_scale;
            bias_d[coef_addr]  = coef_bias;
        end

        if (ch_clear) begin
            ch_d = '0;
        end else if (accept_c) begin
            ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
        end

        if (adv_c) begin
            s1_v_d     = accept_c;
            s1_x_d     = in_data;
            s1_scale_d = scale_q[ch_q];
            s1_bias_d  = bias_q[ch_q];
            s1_ch_d    = ch_q;
            s1_relu_d  = relu_en;

            s2_v_d    = s1_v_q;
            s2_sum_d  = sum_c;
            s2_ch_d   = s1_ch_q;
            s2_relu_d = s1_relu_q;

            out_valid_d = s2_v_q;
            out_data_d  = res_c;
            out_ch_d    = s2_ch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scale_q[i] <= ONE_Q;
                bias_q[i]  <= '0;
            end
            ch_q        <= '0;
            s1_v_q      <= 1'b0;
            s1_x_q      <= '0;
            s1_scale_q  <= '0;
            s1_bias_q   <= '0;
            s1_ch_q     <= '0;
            s1_relu_q   <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_sum_q    <= '0;
            s2_ch_q     <= '0;
            s2_relu_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            scale_q     <= scale_d;
            bias_q      <= bias_d;
            ch_q        <= ch_d;
            s1_v_q      <= s1_v_d;
            s1_x_q      <= s1_x_d;
            s1_scale_q  <= s1_scale_d;
            s1_bias_q   <= s1_bias_d;
            s1_ch_q     <= s1_ch_d;
            s1_relu_q   <= s1_relu_d;
            s2_v_q      <= s2_v_d;
            s2_sum_q    <= s2_sum_d;
            s2_ch_q     <= s2_ch_d;
            s2_relu_q   <= s2_relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

endmodule
